// File: rtl/mul_result_collector.sv
// rtl/mul_result_collector.sv - N-channel FIFO-buffered result collector with arbitrated valid/ready output
// Each channel has its own small FIFO; one output register serialises the results with source tags.
module mul_result_collector #(
  parameter int WIDTH    = 32,
  parameter int N_CH     = 2,
  parameter int DEPTH    = 2,
  parameter int ARB_MODE = 0,
  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] ch_res,
  input  logic [N_CH-1:0]       ch_rdy,
  output logic [WIDTH-1:0]      res,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CW-1:0]         res_ch,
  output logic [N_CH-1:0]       res_sel,
  output logic [N_CH-1:0]       ovf,
  input  logic                  ovf_clr
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [0:0]  OUT_EMPTY = 1'b0;
  localparam logic [0:0]  OUT_HOLD  = 1'b1;

  logic [WIDTH-1:0] mem [N_CH][DEPTH];
  logic [AW:0]      wr_ptr [N_CH];
  logic [AW:0]      rd_ptr [N_CH];
  logic [0:0]       state;
  logic [CW-1:0]    rr_ptr;

  logic [N_CH-1:0]  nonempty, full, pop, push, drop, gnt_sel;
  logic [CW-1:0]    gnt;
  logic             do_grant;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nonempty[i] = wr_ptr[i] != rd_ptr[i];
      full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt = '0;
    if (ARB_MODE == 1) begin
      for (int k = N_CH - 1; k >= 0; k--)
        if (nonempty[k]) gnt = CW'(k);
    end else begin
      for (int k = N_CH; k >= 1; k--)
        if (nonempty[CW'((int'(rr_ptr) + k) % N_CH)]) gnt = CW'((int'(rr_ptr) + k) % N_CH);
    end
  end

  assign do_grant  = ((state == OUT_EMPTY) || res_ready) && (|nonempty);
  assign res_valid = (state == OUT_HOLD);

  // A pop of a full FIFO frees the slot the same-edge push writes into.
  always_comb begin
    gnt_sel      = '0;
    gnt_sel[gnt] = 1'b1;
    pop          = do_grant ? gnt_sel : '0;
    push         = ch_rdy & (~full | pop);
    drop         = ch_rdy & full & ~pop;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++)
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= ch_res[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= OUT_EMPTY;
      res     <= '0;
      res_ch  <= '0;
      res_sel <= '0;
      rr_ptr  <= CW'(N_CH - 1);
      ovf     <= '0;
    end else begin
      ovf <= (ovf & {N_CH{~ovf_clr}}) | drop;
      if (do_grant) begin
        res     <= mem[gnt][rd_ptr[gnt][AW-1:0]];
        res_ch  <= gnt;
        res_sel <= gnt_sel;
        rr_ptr  <= gnt;
        state   <= OUT_HOLD;
      end else if ((state == OUT_HOLD) && res_ready) begin
        res_sel <= '0;
        state   <= OUT_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_mul_result_collector.sv
// tb/tb_mul_result_collector.sv - bench for mul_result_collector, round-robin and fixed-priority instances
// Both instances see the same stimulus; a queue-based model of each is compared every cycle.
module tb_mul_result_collector;
  localparam int NC = 4;
  localparam int DP = 2;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [NC*32-1:0] ch_res = '0;
  logic [NC-1:0] ch_rdy    = '0;
  logic          res_ready = 1'b0;
  logic          ovf_clr   = 1'b0;

  logic [31:0]   rr_res, fp_res;
  logic          rr_valid, fp_valid;
  logic [1:0]    rr_ch, fp_ch;
  logic [NC-1:0] rr_sel, fp_sel, rr_ovf, fp_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_result_collector #(.WIDTH(32), .N_CH(NC), .DEPTH(DP), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .ch_res(ch_res), .ch_rdy(ch_rdy), .res(rr_res), .res_valid(rr_valid),
    .res_ready(res_ready), .res_ch(rr_ch), .res_sel(rr_sel), .ovf(rr_ovf), .ovf_clr(ovf_clr));

  mul_result_collector #(.WIDTH(32), .N_CH(NC), .DEPTH(DP), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .ch_res(ch_res), .ch_rdy(ch_rdy), .res(fp_res), .res_valid(fp_valid),
    .res_ready(res_ready), .res_ch(fp_ch), .res_sel(fp_sel), .ovf(fp_ovf), .ovf_clr(ovf_clr));

  // Model: index 0 is round-robin, index 1 is fixed priority.
  logic [31:0]   mq [2*NC][$];
  logic          mv [2];
  logic [31:0]   mres [2];
  int            mch [2];
  int            mlast [2];
  logic [NC-1:0] movf [2];

  always @(posedge clk or negedge rst) begin
    int g, c;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        mv[m] = 1'b0; mres[m] = '0; mch[m] = 0; mlast[m] = NC - 1; movf[m] = '0;
      end
      for (int q = 0; q < 2*NC; q++) mq[q].delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        g = -1;
        if (!mv[m] || res_ready) begin
          for (int k = 0; k < NC; k++) begin
            c = (m == 1) ? k : (mlast[m] + 1 + k) % NC;
            if (g < 0 && mq[m*NC+c].size() > 0) g = c;
          end
        end
        if (g >= 0) begin
          mres[m] = mq[m*NC+g].pop_front();
          mch[m] = g; mv[m] = 1'b1; mlast[m] = g;
        end else if (mv[m] && res_ready) begin
          mv[m] = 1'b0;
        end
        if (ovf_clr) movf[m] = '0;
        for (int k = 0; k < NC; k++) begin
          if (ch_rdy[k]) begin
            if (mq[m*NC+k].size() < DP) mq[m*NC+k].push_back(ch_res[k*32 +: 32]);
            else movf[m][k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string n, input int m, input logic v, input logic [31:0] r,
                     input logic [1:0] ch, input logic [NC-1:0] sel, input logic [NC-1:0] ov);
    chk({n, "_valid"}, 64'(v), 64'(mv[m]));
    chk({n, "_res"}, 64'(r), 64'(mres[m]));
    chk({n, "_ch"}, 64'(ch), 64'(mch[m]));
    chk({n, "_sel"}, 64'(sel), mv[m] ? 64'(1 << mch[m]) : 64'd0);
    chk({n, "_ovf"}, 64'(ov), 64'(movf[m]));
  endtask

  always @(negedge clk) begin
    cmp("rr", 0, rr_valid, rr_res, rr_ch, rr_sel, rr_ovf);
    cmp("fp", 1, fp_valid, fp_res, fp_ch, fp_sel, fp_ovf);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NC-1:0] rdy, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    ch_rdy = rdy;
    ch_res = {w3, w2, w1, w0};
    tick();
    ch_rdy = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    tick();
    chk("rst_valid", rr_valid, 0);
    chk("rst_res", rr_res, 0);
    chk("rst_sel", rr_sel, 0);
    chk("rst_ovf", fp_ovf, 0);
    rst = 1'b1;

    // single word, latency and release
    push(4'b0001, 32'h3F800000, 0, 0, 0);
    chk("t1_valid_e", rr_valid, 0);
    tick();
    chk("t1_valid_e1", rr_valid, 1);
    chk("t1_res", rr_res, 32'h3F800000);
    chk("t1_ch", rr_ch, 0);
    chk("t1_sel", rr_sel, 4'b0001);
    res_ready = 1'b1;
    tick();
    chk("t1_released", rr_valid, 0);
    chk("t1_sel_clr", rr_sel, 0);
    chk("t1_res_kept", rr_res, 32'h3F800000);

    // simultaneous arrival, back-to-back
    do_reset();
    push(4'b0011, 32'h40000000, 32'h40400000, 0, 0);
    tick();
    chk("t2_first", rr_res, 32'h40000000);
    chk("t2_first_ch", rr_ch, 0);
    tick();
    chk("t2_second_valid", rr_valid, 1);
    chk("t2_second", rr_res, 32'h40400000);
    chk("t2_second_ch", rr_ch, 1);
    chk("t2_fp_second", fp_res, 32'h40400000);
    tick();
    chk("t2_done", rr_valid, 0);

    // backpressure
    res_ready = 1'b0;
    push(4'b0100, 0, 0, 32'hC0A00000, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", rr_valid, 1);
      chk("t3_hold_res", rr_res, 32'hC0A00000);
      chk("t3_hold_ch", rr_ch, 2);
      chk("t3_hold_sel", rr_sel, 4'b0100);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t3_accepted_once", rr_valid, 0);

    // overflow on ch1 with depth 2
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(4'b0010, 0, 32'h41000000 + 32'(i), 0, 0);
    chk("t4_hold_w1", rr_res, 32'h41000001);
    chk("t4_ovf", rr_ovf, 4'b0010);
    chk("t4_fp_ovf", fp_ovf, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", rr_ovf, 0);
    res_ready = 1'b1;
    tick();
    chk("t4_w2", rr_res, 32'h41000002);
    tick();
    chk("t4_w3", rr_res, 32'h41000003);
    tick();
    chk("t4_drained", rr_valid, 0);

    // overflow beats a same-cycle clear
    res_ready = 1'b0;
    for (int i = 5; i <= 7; i++) push(4'b0010, 0, 32'h41000000 + 32'(i), 0, 0);
    ovf_clr = 1'b1;
    push(4'b0010, 0, 32'h41000008, 0, 0);
    ovf_clr = 1'b0;
    chk("t4_ovf_wins", rr_ovf, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr2", rr_ovf, 0);

    // push and pop on a full FIFO in the same edge
    res_ready = 1'b1;
    push(4'b0010, 0, 32'h41000009, 0, 0);
    chk("t4_pp_res", rr_res, 32'h41000006);
    chk("t4_pp_no_ovf", rr_ovf, 0);
    tick();
    chk("t4_pp_w7", rr_res, 32'h41000007);
    tick();
    chk("t4_pp_w9", rr_res, 32'h41000009);
    tick();
    chk("t4_pp_done", rr_valid, 0);

    // fairness versus fixed priority under full load
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ch_rdy = 4'b1111;
      for (int c = 0; c < NC; c++) ch_res[c*32 +: 32] = 32'h10000000 * c + 32'(cyc);
      tick();
      if (rr_valid && n < 8) begin
        chk("t5_rr_order", rr_ch, 64'(n % 4));
        n++;
      end
      if (fp_valid) chk("t5_fp_ch0", fp_ch, 0);
    end
    chk("t5_rr_count", n, 8);
    chk("t5_rr_ovf_set", rr_ovf != 0, 1);

    // asynchronous reset mid-burst
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rr_valid", rr_valid, 0);
    chk("t6_fp_valid", fp_valid, 0);
    chk("t6_rr_ovf", rr_ovf, 0);
    chk("t6_fp_sel", fp_sel, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_idle_after_release", rr_valid, 0);
    tick();
    chk("t6_rr_first_ch", rr_ch, 0);
    chk("t6_fp_first_ch", fp_ch, 0);
    chk("t6_rr_first_valid", rr_valid, 1);
    ch_rdy = '0;
    repeat (12) tick();
    chk("t6_rr_drained", rr_valid, 0);
    chk("t6_fp_drained", fp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_result_collector.md
Name: mul_result_collector

Overview:
- Parametrised N-channel result collector for the IEEE-754 multiplier array.
- Accepts per-channel result pulses (res/res_rdy style) from N_CH multiplier instances and buffers each channel in a small FIFO.
- Serialises buffered results onto one output port with a valid/ready handshake, using round-robin or fixed-priority arbitration.
- Tags each output word with its source channel; flags per-channel overflow.

Parameters:
- WIDTH, 32: result word width in bits.
- N_CH, 2: number of input channels (≥2).
- DEPTH, 2: per-channel FIFO depth (power of 2, ≥2).
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_res  in  N_CH*WIDTH  channel results; channel i occupies bits [i*WIDTH +: WIDTH].
- ch_rdy  in  N_CH  per-channel one-cycle strobe; ch_res slice is valid while high.
- res  out  WIDTH  output result word.
- res_valid  out  1  res, res_ch and res_sel are valid.
- res_ready  in  1  consumer accepts the word when res_valid & res_ready.
- res_ch  out  max(1,$clog2(N_CH))  source channel index.
- res_sel  out  N_CH  one-hot source channel; all zero when res_valid=0.
- ovf  out  N_CH  sticky per-channel overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0, asynchronous): res=0, res_valid=0, res_ch=0, res_sel=0, ovf=0, all FIFOs empty, RR pointer=N_CH-1 (channel 0 is served first).
- Push: at a rising edge with ch_rdy[i]=1, the ch_res slice is written to FIFO i.
- Full FIFO: if FIFO i is full and no pop of i occurs in the same cycle, the word is dropped and ovf[i] is set.
- Push+pop on a full FIFO in the same cycle: legal; no drop, no ovf.
- ovf_clr=1 clears all ovf bits. A same-cycle overflow wins and its bit stays set.
- Output register FSM, two states:
  - OUT_EMPTY: if any FIFO is non-empty, grant one channel, pop its head into res, set res_ch, res_sel and res_valid=1, go to OUT_HOLD. Otherwise stay.
  - OUT_HOLD: if res_ready=0, hold res, res_ch and res_sel stable. If res_ready=1 and a FIFO is non-empty, grant and reload in the same edge (back-to-back, no bubble). If res_ready=1 and all FIFOs are empty, clear res_valid and res_sel (res keeps its last value) and go to OUT_EMPTY.
- Latency: ch_rdy sampled at edge E; res_valid is high after edge E+1 when the output is idle and no other channel is pending. Throughput is 1 word/cycle.
- Round-robin (ARB_MODE=0):
  - Search starts at pointer+1 and wraps modulo N_CH.
  - On grant, pointer = granted index.
  - A channel with continuous traffic waits at most N_CH-1 grants.
- Fixed priority (ARB_MODE=1): lowest-index non-empty FIFO wins; the pointer is unused.
- Arbitration sees FIFO state before the same-edge push, so a word pushed at edge E is never granted at E.
- FIFO pointers: log2(DEPTH)+1 bits with a wrap bit. Empty = pointers equal; full = MSBs differ and the rest are equal.
- Reset mid-operation: all buffered and held words are discarded immediately; no partial output.
- res_ready is ignored while res_valid=0.

Test Plan:
- Single word: reset, then ch_rdy=01 with ch0=0x3F800000 -> res_valid=1 after edge E+1, res=0x3F800000, res_ch=0, res_sel=01; res_ready=1 -> res_valid=0 on next edge.
- Simultaneous arrival, RR, N_CH=2: ch_rdy=11, ch0=0x40000000, ch1=0x40400000, res_ready=1 -> output ch0 (0x40000000) then ch1 (0x40400000) on consecutive cycles, no bubble.
- Backpressure: res_ready=0 for 5 cycles with a word held -> res, res_ch and res_sel unchanged; then res_ready=1 -> word accepted exactly once.
- Overflow, DEPTH=2: res_ready=0, 4 pushes on ch1 -> output holds word1, FIFO holds words 2-3, word4 dropped, ovf=10. ovf_clr pulse -> ovf=00.
- Fairness, N_CH=4, ARB_MODE=0: all channels pushing every cycle, res_ready=1 -> res_ch sequence 0,1,2,3,0,...
- Fixed priority, ARB_MODE=1: same stimulus -> res_ch stays 0. Async reset asserted mid-burst -> res_valid=0 immediately, ovf=0, next output after release comes from ch0.
